word_byte_assembler: RTL and testbench

- Receive-side counterpart of the 32-bit typed word path: accepts a byte stream over a valid/ready handshake.
- Reassembles the bytes little-endian into WIDTH-bit words of the package word type.
- Presents each completed word on a valid/ready output, together with a count of the valid bytes.
- Sits between a byte-wide link receiver and the word-wide core datapath.

---
 rtl/word_byte_assembler.sv | 119 +++++++++++
 tb/tb_word_byte_assembler.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/word_byte_assembler.sv
// Receive-side byte-to-word reassembler: packs a little-endian byte stream into
// WIDTH-bit words, closing a word early on in_last and zero-filling the unused bytes.
module word_byte_assembler #(
    parameter int WIDTH  = 32,
    parameter int NBYTES = WIDTH / 8,
    parameter int CW     = $clog2(NBYTES) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CW-1:0]    out_nbytes,
    output logic             out_last
);
    localparam int IW = $clog2(NBYTES);

    typedef logic [WIDTH-1:0] word_t;
    typedef enum logic {FILL = 1'b0, HOLD = 1'b1} state_t;

    state_t                 state_q, state_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic [NBYTES-1:0][7:0] shadow_q, shadow_d;
    word_t                  out_data_q, out_data_d;
    logic [CW-1:0]          out_nbytes_q, out_nbytes_d;
    logic                   out_last_q, out_last_d;

    logic [NBYTES-1:0][7:0] load_bytes;
    logic                   byte_xfer;
    logic                   word_xfer;
    logic                   word_done;

    assign in_ready  = (state_q == FILL) || out_ready;
    assign byte_xfer = in_valid && in_ready;
    assign word_xfer = (state_q == HOLD) && out_ready;
    assign word_done = (idx_q == IW'(NBYTES - 1)) || in_last;

    // Word image for a load: shadow below idx, the arriving byte at idx, zeros above.
    generate
        for (genvar gi = 0; gi < NBYTES; gi++) begin : g_load
            assign load_bytes[gi] = (IW'(gi) == idx_q) ? in_data :
                                    (IW'(gi) <  idx_q) ? shadow_q[gi] : 8'h00;
        end
    endgenerate

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        shadow_d     = shadow_q;
        out_data_d   = out_data_q;
        out_nbytes_d = out_nbytes_q;
        out_last_d   = out_last_q;
        case (state_q)
            FILL: begin
                if (byte_xfer) begin
                    if (word_done) begin
                        out_data_d   = load_bytes;
                        out_nbytes_d = CW'(idx_q) + CW'(1);
                        out_last_d   = in_last;
                        idx_d        = '0;
                        shadow_d     = '0;
                        state_d      = HOLD;
                    end else begin
                        shadow_d[idx_q] = in_data;
                        idx_d           = idx_q + IW'(1);
                    end
                end
            end
            HOLD: begin
                if (word_xfer) begin
                    shadow_d = '0;
                    idx_d    = '0;
                    state_d  = FILL;
                    if (byte_xfer) begin
                        // A lone in_last byte is itself a complete one-byte word.
                        if (in_last) begin
                            out_data_d   = {{(WIDTH - 8){1'b0}}, in_data};
                            out_nbytes_d = CW'(1);
                            out_last_d   = 1'b1;
                            state_d      = HOLD;
                        end else begin
                            shadow_d[0] = in_data;
                            idx_d       = IW'(1);
                        end
                    end
                end
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= FILL;
            idx_q        <= '0;
            shadow_q     <= '0;
            out_data_q   <= '0;
            out_nbytes_q <= '0;
            out_last_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            shadow_q     <= shadow_d;
            out_data_q   <= out_data_d;
            out_nbytes_q <= out_nbytes_d;
            out_last_q   <= out_last_d;
        end
    end

    assign out_valid  = (state_q == HOLD);
    assign out_data   = out_data_q;
    assign out_nbytes = out_nbytes_q;
    assign out_last   = out_last_q;

endmodule

// File: tb/tb_word_byte_assembler.sv
// Bench for word_byte_assembler: directed scenarios plus random traffic, all checked
// against a byte-queue model that packs accepted bytes into expected words.
module tb_word_byte_assembler;
    localparam int WIDTH = 32;
    localparam int NB    = WIDTH / 8;
    localparam int CW    = $clog2(NB) + 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [7:0]       in_data = 8'h00;
    logic             in_last = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] out_data;
    logic [CW-1:0]    out_nbytes;
    logic             out_last;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [WIDTH-1:0] data;
        logic [CW-1:0]    nb;
        logic             last;
    } word_s;

    typedef struct {
        logic             gv, ir, ev, bx, wx, ordy;
        logic [WIDTH-1:0] data;
        logic [CW-1:0]    nb;
        logic             last;
    } obs_s;

    word_s      exp_q[$];
    logic [7:0] acc[$];

    word_byte_assembler #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_nbytes(out_nbytes), .out_last(out_last)
    );

    always #5 clk = ~clk;

    // Reference: collect accepted bytes; a word closes at NB bytes or on a last byte.
    task automatic model_byte(input logic [7:0] d, input logic l);
        word_s w;
        acc.push_back(d);
        if (acc.size() == NB || l) begin
            w.data = '0;
            foreach (acc[i]) w.data = w.data | (WIDTH'(acc[i]) << (8 * i));
            w.nb   = CW'(acc.size());
            w.last = l;
            exp_q.push_back(w);
            acc.delete();
        end
    endtask

    // Drive one cycle at the falling edge, sample just after, then let the rising edge happen.
    task automatic cycle(input logic iv, input logic [7:0] d, input logic l, input logic ordy,
                         output obs_s o);
        @(negedge clk);
        in_valid  = iv;
        in_data   = d;
        in_last   = l;
        out_ready = ordy;
        #1;
        o.gv   = out_valid;
        o.ir   = in_ready;
        o.ev   = (exp_q.size() != 0);
        o.ordy = ordy;
        o.bx   = iv && in_ready;
        o.wx   = out_valid && ordy;
        o.data = out_data;
        o.nb   = out_nbytes;
        o.last = out_last;
        if (o.wx) $display("word   data=%h nbytes=%0d last=%0b", o.data, o.nb, o.last);
        if (o.bx) model_byte(d, l);
        @(posedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        out_ready = 1'b0;
        #12;
        checks++;
        if (out_valid !== 1'b0 || out_data !== '0 || out_nbytes !== '0 || out_last !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: valid=%b data=%h nbytes=%0d last=%b, expected all 0",
                     out_valid, out_data, out_nbytes, out_last);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %b expected 1", in_ready);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_full_word();
        logic [7:0] b [6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h00, 8'h00};
        logic [WIDTH-1:0] seen[$];
        obs_s o;
        word_s e;
        for (int k = 0; k < 6; k++) begin
            cycle(k < 4, b[k], 1'b0, 1'b1, o);
            checks++;
            if (o.gv !== o.ev || o.ir !== 1'b1) begin
                errors++;
                $display("FAIL full_word_hs: valid=%b in_ready=%b expected %b/1", o.gv, o.ir, o.ev);
            end
            if (o.wx && exp_q.size() != 0) begin
                e = exp_q.pop_front();
                seen.push_back(o.data);
                checks++;
                if (o.data !== e.data || o.nb !== e.nb || o.last !== e.last || o.nb !== CW'(4)) begin
                    errors++;
                    $display("FAIL full_word: got %h/%0d/%b expected %h/%0d/%b",
                             o.data, o.nb, o.last, e.data, e.nb, e.last);
                end
            end
        end
        checks++;
        if (seen.size() != 1 || seen[0] !== 32'h44332211) begin
            errors++;
            $display("FAIL full_word_seen: got %0d words expected one 44332211", seen.size());
        end
    endtask

    task automatic test_short_frame();
        logic [7:0] b [8] = '{8'hAA, 8'hBB, 8'h01, 8'h02, 8'h03, 8'h04, 8'h00, 8'h00};
        logic       v [8] = '{1, 1, 1, 1, 1, 1, 0, 0};
        logic       l [8] = '{0, 1, 0, 0, 0, 0, 0, 0};
        logic [WIDTH-1:0] seen[$];
        obs_s o;
        word_s e;
        for (int k = 0; k < 8; k++) begin
            cycle(v[k], b[k], l[k], 1'b1, o);
            checks++;
            if (o.gv !== o.ev || o.ir !== 1'b1) begin
                errors++;
                $display("FAIL short_hs: valid=%b in_ready=%b expected %b/1", o.gv, o.ir, o.ev);
            end
            if (o.wx && exp_q.size() != 0) begin
                e = exp_q.pop_front();
                seen.push_back(o.data);
                checks++;
                if (o.data !== e.data || o.nb !== e.nb || o.last !== e.last) begin
                    errors++;
                    $display("FAIL short_word: got %h/%0d/%b expected %h/%0d/%b",
                             o.data, o.nb, o.last, e.data, e.nb, e.last);
                end
            end
        end
        checks++;
        if (seen.size() != 2 || seen[0] !== 32'h0000BBAA || seen[1] !== 32'h04030201) begin
            errors++;
            $display("FAIL short_seen: got %0d words expected 0000bbaa,04030201", seen.size());
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] b [14] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55,
                               8'h55, 8'h66, 8'h77, 8'h88, 8'h00};
        logic       r [14] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1};
        logic [WIDTH-1:0] seen[$];
        obs_s o;
        word_s e;
        for (int k = 0; k < 14; k++) begin
            cycle(k < 13, b[k], 1'b0, r[k], o);
            checks++;
            if (o.gv !== o.ev || o.ir !== (!o.ev || o.ordy)) begin
                errors++;
                $display("FAIL bp_hs: valid=%b in_ready=%b expected %b/%b",
                         o.gv, o.ir, o.ev, !o.ev || o.ordy);
            end
            if (k >= 4 && k <= 8) begin
                checks++;
                if (o.data !== 32'h44332211 || o.gv !== 1'b1 || o.ir !== 1'b0) begin
                    errors++;
                    $display("FAIL bp_stall: data=%h valid=%b in_ready=%b expected 44332211/1/0",
                             o.data, o.gv, o.ir);
                end
            end
            if (o.wx && exp_q.size() != 0) begin
                e = exp_q.pop_front();
                seen.push_back(o.data);
                checks++;
                if (o.data !== e.data || o.nb !== e.nb || o.last !== e.last) begin
                    errors++;
                    $display("FAIL bp_word: got %h/%0d/%b expected %h/%0d/%b",
                             o.data, o.nb, o.last, e.data, e.nb, e.last);
                end
            end
        end
        checks++;
        if (seen.size() != 2 || seen[0] !== 32'h44332211 || seen[1] !== 32'h88776655) begin
            errors++;
            $display("FAIL bp_seen: got %0d words expected 44332211,88776655", seen.size());
        end
    endtask

    task automatic test_back_to_back();
        int   wcyc[$];
        obs_s o;
        word_s e;
        for (int k = 0; k < 14; k++) begin
            cycle(k < 12, 8'(k), 1'b0, 1'b1, o);
            checks++;
            if (o.gv !== o.ev || o.ir !== 1'b1 || (k < 12 && !o.bx)) begin
                errors++;
                $display("FAIL b2b_hs: cycle %0d valid=%b in_ready=%b expected %b/1", k, o.gv, o.ir, o.ev);
            end
            if (o.wx && exp_q.size() != 0) begin
                e = exp_q.pop_front();
                wcyc.push_back(k);
                checks++;
                if (o.data !== e.data || o.nb !== e.nb || o.last !== e.last) begin
                    errors++;
                    $display("FAIL b2b_word: got %h/%0d/%b expected %h/%0d/%b",
                             o.data, o.nb, o.last, e.data, e.nb, e.last);
                end
            end
        end
        checks++;
        if (wcyc.size() != 3 || wcyc[0] != 4 || wcyc[1] != 8 || wcyc[2] != 12) begin
            errors++;
            $display("FAIL b2b_spacing: got %0d words expected 3 at cycles 4,8,12", wcyc.size());
        end
    endtask

    task automatic test_hold_single();
        logic [7:0] b [8] = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'h7E, 8'h00, 8'h00, 8'h00};
        logic       r [8] = '{0, 0, 0, 0, 1, 0, 1, 1};
        obs_s o;
        word_s e;
        for (int k = 0; k < 8; k++) begin
            cycle(k < 5, b[k], k == 4, r[k], o);
            checks++;
            if (o.gv !== o.ev || o.ir !== (!o.ev || o.ordy)) begin
                errors++;
                $display("FAIL single_hs: valid=%b in_ready=%b expected %b/%b",
                         o.gv, o.ir, o.ev, !o.ev || o.ordy);
            end
            if (k == 5) begin
                checks++;
                if (o.gv !== 1'b1 || o.data !== 32'h0000007E || o.nb !== CW'(1) || o.last !== 1'b1) begin
                    errors++;
                    $display("FAIL single_word: got %b/%h/%0d/%b expected 1/0000007e/1/1",
                             o.gv, o.data, o.nb, o.last);
                end
            end
            if (o.wx && exp_q.size() != 0) begin
                e = exp_q.pop_front();
                checks++;
                if (o.data !== e.data || o.nb !== e.nb || o.last !== e.last) begin
                    errors++;
                    $display("FAIL single_model: got %h/%0d/%b expected %h/%0d/%b",
                             o.data, o.nb, o.last, e.data, e.nb, e.last);
                end
            end
        end
    endtask

    task automatic test_async_reset();
        logic [7:0] b [8] = '{8'h5A, 8'h5B, 8'hD0, 8'hD1, 8'hD2, 8'hD3, 8'h00, 8'h00};
        logic [WIDTH-1:0] seen[$];
        obs_s o;
        word_s e;
        for (int k = 0; k < 8; k++) begin
            if (k == 2) begin
                #2 rst = 1'b1;
                #1;
                checks++;
                if (out_valid !== 1'b0 || out_data !== '0 || out_nbytes !== '0 || out_last !== 1'b0) begin
                    errors++;
                    $display("FAIL async_reset: valid=%b data=%h nbytes=%0d last=%b expected all 0",
                             out_valid, out_data, out_nbytes, out_last);
                end
                acc.delete();
                exp_q.delete();
                #1 rst = 1'b0;
            end
            cycle(k < 6, b[k], 1'b0, 1'b1, o);
            checks++;
            if (o.gv !== o.ev || o.ir !== 1'b1) begin
                errors++;
                $display("FAIL areset_hs: valid=%b in_ready=%b expected %b/1", o.gv, o.ir, o.ev);
            end
            if (o.wx && exp_q.size() != 0) begin
                e = exp_q.pop_front();
                seen.push_back(o.data);
                checks++;
                if (o.data !== e.data || o.nb !== e.nb || o.last !== e.last) begin
                    errors++;
                    $display("FAIL areset_word: got %h/%0d/%b expected %h/%0d/%b",
                             o.data, o.nb, o.last, e.data, e.nb, e.last);
                end
            end
        end
        checks++;
        if (seen.size() != 1 || seen[0] !== 32'hD3D2D1D0) begin
            errors++;
            $display("FAIL areset_seen: got %0d words expected one d3d2d1d0", seen.size());
        end
    endtask

    task automatic test_random();
        obs_s o;
        word_s e;
        logic iv, l, r;
        logic [7:0] d;
        for (int k = 0; k < 420; k++) begin
            iv = (k < 400) ? ($urandom_range(0, 3) != 0) : (k == 400);
            d  = 8'($urandom);
            l  = (k < 400) ? ($urandom_range(0, 5) == 0) : 1'b1;
            r  = (k < 400) ? ($urandom_range(0, 3) != 0) : 1'b1;
            cycle(iv, d, l, r, o);
            checks++;
            if (o.gv !== o.ev || o.ir !== (!o.ev || o.ordy)) begin
                errors++;
                $display("FAIL rand_hs: cycle %0d valid=%b in_ready=%b expected %b/%b",
                         k, o.gv, o.ir, o.ev, !o.ev || o.ordy);
            end
            if (o.wx && exp_q.size() != 0) begin
                e = exp_q.pop_front();
                checks++;
                if (o.data !== e.data || o.nb !== e.nb || o.last !== e.last) begin
                    errors++;
                    $display("FAIL rand_word: cycle %0d got %h/%0d/%b expected %h/%0d/%b",
                             k, o.data, o.nb, o.last, e.data, e.nb, e.last);
                end
            end
        end
        checks++;
        if (exp_q.size() != 0 || acc.size() != 0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL rand_drain: pending=%0d partial=%0d out_valid=%b expected 0/0/0",
                     exp_q.size(), acc.size(), out_valid);
        end
    endtask

    initial begin
        test_reset();
        test_full_word();
        test_short_frame();
        test_backpressure();
        test_back_to_back();
        test_hold_single();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
